debounce_edge: RTL and testbench
================================

Name: debounce_edge

Overview:
- Conditions a raw, asynchronous, bouncy input (push-button, switch, external strobe) into clean single-cycle event pulses.
- Sits directly upstream of the pulse-stretching stage. pulse_o is intended to drive that stage's input pulse to produce human-visible indications (LEDs, beepers).
- Also provides the debounced level, release pulses and hold-to-auto-repeat pulses for UI logic.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops on btn_i (>=2).
- STABLE_CYCLES, 1000: consecutive identical synchronized samples required to accept a level change (>=1).
- REPEAT_DELAY, 50000: cycles from accepted press to first repeat pulse. 0 disables auto-repeat; the FSM stays IDLE.
- REPEAT_RATE, 10000: cycles between subsequent repeat pulses (>=1).
- Counter widths are derived with $clog2 of the respective parameter (minimum 1 bit).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low
- btn_i  in  1  raw asynchronous input, active-high
- level_o  out  1  debounced level
- rise_o  out  1  one-cycle pulse on accepted 0->1
- fall_o  out  1  one-cycle pulse on accepted 1->0
- repeat_o  out  1  one-cycle auto-repeat pulse while held
- pulse_o  out  1  rise_o | repeat_o, combinational OR of registered signals

Behaviour:
- Reset (rst_ni low at an edge):
  - All synchronizer flops, counters, level_o, rise_o, fall_o and repeat_o go to 0.
  - FSM goes to IDLE.
  - Reset dominates all other events.
- Synchronizer: btn_s is btn_i delayed through SYNC_STAGES flops. No other logic touches btn_i.
- Debounce counter cnt:
  - At each edge, if btn_s == level_o then cnt <= 0.
  - Else if cnt == STABLE_CYCLES-1 then level_o <= btn_s and cnt <= 0.
  - Else cnt <= cnt+1.
- Single-sample glitch: any sample equal to level_o restarts the count.
- Pulse timing: rise_o/fall_o are registered and high exactly in the cycle level_o first shows its new value. Never both high.
- Latency: the first edge that samples btn_i high is edge 1. level_o and rise_o rise after edge SYNC_STAGES+STABLE_CYCLES. Release latency is the same.
- Auto-repeat FSM, with counter rcnt:
  - IDLE: on the edge that sets level_o to 1 -> DELAY, rcnt <= 0.
  - DELAY: rcnt increments each edge. At rcnt == REPEAT_DELAY-1: repeat_o <= 1, rcnt <= 0, -> REPEAT.
  - REPEAT: rcnt increments. At rcnt == REPEAT_RATE-1: repeat_o <= 1, rcnt <= 0, stay in REPEAT.
  - Release: the edge that clears level_o forces IDLE from any state. repeat_o must be 0 in the fall_o cycle, even if a repeat would have coincided (release wins).
- repeat_o is never high in the same cycle as rise_o.
- Counters never wrap; each is bounded by its compare value.
- btn_i held high through reset release: level_o restarts at 0 and a fresh rise_o occurs SYNC_STAGES+STABLE_CYCLES edges after the first non-reset edge.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3):
1. Clean press: btn_i 0->1 before edge 1, then held.
   - level_o=1 and rise_o=1 after edge 6.
   - rise_o=0 after edge 7.
   - pulse_o mirrors rise_o.
2. Bounce: btn_s pattern 1,1,1,0,1,1,1,1.
   - No rise_o during the first burst.
   - rise_o only after the 4th consecutive 1 of the second burst.
3. Hold: press as in scenario 1 and keep holding.
   - repeat_o single-cycle after edges 16, 19, 22, 25.
   - pulse_o high at 6, 16, 19, 22, 25.
   - No other pulses.
4. Release in DELAY: btn_i drops so that level_o clears after edge 12.
   - fall_o=1 after edge 12, one cycle.
   - No repeat_o at any time.
   - FSM back in IDLE.
5. Coincident release: time the release so level_o clears on the same edge a repeat is due (edge 19).
   - fall_o=1 and repeat_o=0 at that cycle.
6. Reset mid-REPEAT: rst_ni low for 2 edges with btn_i held high.
   - All outputs 0 after the first reset edge.
   - After release, rise_o after the 6th non-reset edge.
   - Repeat_o then follows 10/3 spacing.

Source files
------------

// File: rtl/debounce_edge_if.sv
// rtl/debounce_edge_if.sv - button/event signal bundle for debounce_edge
// Purpose: groups the raw input and the conditioned outputs of debounce_edge.
// Signals:
//   btn_i    raw asynchronous input, active-high
//   level_o  debounced level
//   rise_o   one-cycle pulse on accepted 0->1
//   fall_o   one-cycle pulse on accepted 1->0
//   repeat_o one-cycle auto-repeat pulse while held
//   pulse_o  rise_o | repeat_o
// Modports: master drives btn_i, slave (the debouncer) drives the outputs.
interface debounce_edge_if;
    logic btn_i;
    logic level_o;
    logic rise_o;
    logic fall_o;
    logic repeat_o;
    logic pulse_o;

    modport master (
        output btn_i,
        input  level_o,
        input  rise_o,
        input  fall_o,
        input  repeat_o,
        input  pulse_o
    );

    modport slave (
        input  btn_i,
        output level_o,
        output rise_o,
        output fall_o,
        output repeat_o,
        output pulse_o
    );
endinterface

// File: rtl/debounce_edge.sv
// rtl/debounce_edge.sv - synchronizer, debouncer, edge pulses and hold-to-repeat
// Purpose: turns a raw bouncy input into a debounced level, single-cycle
//          rise/fall pulses and auto-repeat pulses while held.
// Ports:
//   clk_i   clock
//   rst_ni  synchronous active-low reset
//   bus     debounce_edge_if.slave (btn_i in; level_o, rise_o, fall_o,
//           repeat_o, pulse_o out)
module debounce_edge #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000,
    parameter int REPEAT_DELAY  = 50000,
    parameter int REPEAT_RATE   = 10000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    debounce_edge_if.slave  bus
);

    localparam int CW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int RD_W = (REPEAT_DELAY > 1)  ? $clog2(REPEAT_DELAY)  : 1;
    localparam int RR_W = (REPEAT_RATE > 1)   ? $clog2(REPEAT_RATE)   : 1;
    localparam int RW   = (RD_W > RR_W) ? RD_W : RR_W;

    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);
    localparam bit            REPEAT_EN = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    logic [CW-1:0]          cnt;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   repeat_q;
    logic [RW-1:0]          rcnt;
    state_t                 state;

    logic accept;
    logic rise_evt;
    logic fall_evt;

    assign btn_s    = sync_q[SYNC_STAGES-1];
    // A level change is accepted on the edge where the disagreeing sample
    // has been seen STABLE_CYCLES times in a row.
    assign accept   = (btn_s != level_q) && (cnt == CNT_LAST);
    assign rise_evt = accept &&  btn_s;
    assign fall_evt = accept && !btn_s;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt     <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= rise_evt;
            fall_q <= fall_evt;
            if (btn_s == level_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level_q <= btn_s;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Auto-repeat. A release forces IDLE and suppresses any repeat that
    // would have landed on the same edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            rcnt     <= '0;
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= 1'b0;
            if (fall_evt) begin
                state <= ST_IDLE;
                rcnt  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise_evt && REPEAT_EN) begin
                            state <= ST_DELAY;
                            rcnt  <= '0;
                        end
                    end
                    ST_DELAY: begin
                        if (rcnt == DLY_LAST) begin
                            repeat_q <= 1'b1;
                            rcnt     <= '0;
                            state    <= ST_REPEAT;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (rcnt == RATE_LAST) begin
                            repeat_q <= 1'b1;
                            rcnt     <= '0;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        rcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.level_o  = level_q;
    assign bus.rise_o   = rise_q;
    assign bus.fall_o   = fall_q;
    assign bus.repeat_o = repeat_q;
    assign bus.pulse_o  = rise_q | repeat_q;

endmodule

// File: tb/tb_debounce_edge.sv
// tb/tb_debounce_edge.sv - directed self-checking bench for debounce_edge
module tb_debounce_edge;

    logic clk_i = 1'b0;
    logic rst_ni;

    always #5 clk_i = ~clk_i;

    debounce_edge_if dbi ();

    debounce_edge #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4),
        .REPEAT_DELAY (10),
        .REPEAT_RATE  (3)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (dbi)
    );

    int n_pass = 0;
    int n_chk  = 0;

    logic [63:0] level_m;
    logic [63:0] rise_m;
    logic [63:0] fall_m;
    logic [63:0] rep_m;
    logic [63:0] pulse_m;
    int          bad_excl;

    localparam logic [63:0] PAT_ONES = 64'hFFFF_FFFF_FFFF_FFFE;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_reset();
        rst_ni    = 1'b0;
        dbi.btn_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    // Bit e of pat is the btn_i value presented before edge e; bit e of each
    // mask is the output seen just after edge e.
    task automatic run(input int n, input logic [63:0] pat);
        level_m  = '0;
        rise_m   = '0;
        fall_m   = '0;
        rep_m    = '0;
        pulse_m  = '0;
        bad_excl = 0;
        for (int e = 1; e <= n; e++) begin
            dbi.btn_i = pat[e];
            @(posedge clk_i);
            #1;
            level_m[e] = dbi.level_o;
            rise_m[e]  = dbi.rise_o;
            fall_m[e]  = dbi.fall_o;
            rep_m[e]   = dbi.repeat_o;
            pulse_m[e] = dbi.pulse_o;
            if ((dbi.rise_o && dbi.fall_o) || (dbi.rise_o && dbi.repeat_o) ||
                (dbi.pulse_o !== (dbi.rise_o | dbi.repeat_o)))
                bad_excl++;
        end
    endtask

    function automatic logic [63:0] outs();
        return {59'd0, dbi.level_o, dbi.rise_o, dbi.fall_o, dbi.repeat_o, dbi.pulse_o};
    endfunction

    initial begin
        do_reset();
        chk("reset_outs", outs(), 64'd0);

        // Clean press and hold: rise at 6, repeats at 16,19,22,25
        run(27, PAT_ONES);
        chk("hold_level", level_m, 64'h0FFF_FFC0);
        chk("hold_rise", rise_m, 64'h40);
        chk("hold_fall", fall_m, 64'h0);
        chk("hold_repeat", rep_m, 64'h0249_0000);
        chk("hold_pulse", pulse_m, 64'h0249_0040);
        chk("hold_excl", bad_excl, 0);

        // Bounce: btn_s 1,1,1,0,1,1,1,1 -> rise only at edge 10
        do_reset();
        run(12, 64'hFFFF_FFFF_FFFF_FFEE);
        chk("bounce_rise", rise_m, 64'h400);
        chk("bounce_level", level_m, 64'h1C00);
        chk("bounce_fall", fall_m, 64'h0);
        chk("bounce_excl", bad_excl, 0);

        // Release during DELAY: level clears at edge 12, never repeats
        do_reset();
        run(30, 64'h7E);
        chk("reldly_rise", rise_m, 64'h40);
        chk("reldly_fall", fall_m, 64'h1000);
        chk("reldly_level", level_m, 64'hFC0);
        chk("reldly_repeat", rep_m, 64'h0);
        chk("reldly_excl", bad_excl, 0);

        // Release coinciding with the repeat due at edge 19: release wins
        do_reset();
        run(30, 64'h3FFE);
        chk("coin_fall", fall_m, 64'h8_0000);
        chk("coin_repeat", rep_m, 64'h1_0000);
        chk("coin_level", level_m, 64'h7_FFC0);
        chk("coin_edge19", {62'd0, fall_m[19], rep_m[19]}, 64'd2);
        chk("coin_excl", bad_excl, 0);

        // Reset mid-REPEAT with btn_i held high
        do_reset();
        run(20, PAT_ONES);
        chk("pre_rst_repeat", rep_m, 64'h9_0000);
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        chk("midrst_outs", outs(), 64'd0);
        @(posedge clk_i);
        #1;
        chk("midrst_outs2", outs(), 64'd0);
        rst_ni = 1'b1;
        run(27, PAT_ONES);
        chk("postrst_level", level_m, 64'h0FFF_FFC0);
        chk("postrst_rise", rise_m, 64'h40);
        chk("postrst_repeat", rep_m, 64'h0249_0000);
        chk("postrst_pulse", pulse_m, 64'h0249_0040);
        chk("postrst_excl", bad_excl, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
